// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings and state type for the multi-cycle RV32I controller
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_IFUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SUB    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

endpackage

// File: rtl/rv_mem_wait_timer.sv
// rtl/rv_mem_wait_timer.sv - per-access wait counter with optional timeout compare
module rv_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam bit               TMO_EN = (MEM_TIMEOUT > 0);
    localparam logic [TMO_W-1:0] LIMIT  = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [TMO_W-1:0] r_count;

    // The cycle being waited now counts toward the limit, so fire when the prior count hits LIMIT.
    assign o_timeout = TMO_EN && i_active && !i_ready && (r_count == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n || !i_active || i_ready || o_timeout) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/rv_multicycle_controller.sv
// rtl/rv_multicycle_controller.sv - control FSM for the shared-datapath multi-cycle RV32I core
module rv_multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_BRANCH = 1'b1,
    parameter bit ENABLE_JAL    = 1'b1,
    parameter int MEM_TIMEOUT   = 0,
    parameter int TMO_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       instr_retired,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    logic   w_wait_state;
    logic   w_timeout;
    logic   w_br_legal;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_br_legal   = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    assign state_o      = r_state;

    rv_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_wait_state),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:   w_next = S_FETCH;
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = ENABLE_BRANCH ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:            w_next = ENABLE_JAL ? S_JAL : S_ILLEGAL;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : (w_timeout ? S_FETCH : S_MEMREAD);
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = (mem_ready || w_timeout) ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_ILLEGAL:  w_next = S_FETCH;
            default:    w_next = S_RESET;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_IFUNCT;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;
        mem_fault     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                mem_fault  = w_timeout;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                adr_src   = 1'b1;
                mem_fault = w_timeout;
            end
            S_MEMWB: begin
                result_src    = RES_MEM;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req       = 1'b1;
                mem_write     = 1'b1;
                adr_src       = 1'b1;
                instr_retired = mem_ready;
                mem_fault     = w_timeout;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RFUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_IFUNCT;
            end
            S_ALUWB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                // Unsupported compare kinds are trapped here rather than in DECODE.
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                pc_write      = (funct3 == F3_BEQ) ? zero : ((funct3 == F3_BNE) ? ~zero : 1'b0);
                instr_retired = w_br_legal;
                illegal_op    = ~w_br_legal;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                pc_write  = 1'b1;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// tb/tb_rv_multicycle_controller.sv - directed self-checking bench for rv_multicycle_controller
module tb_rv_multicycle_controller;

    // Output vector: {req,read,write,adr,ir,pc,regw, srca, srcb, res, aluop, retired, illegal, fault}
    localparam logic [17:0] E_ZERO    = 18'd0;
    localparam logic [17:0] E_FETCH_W = {7'b1100000, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000};
    localparam logic [17:0] E_FETCH_R = {7'b1100110, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000};
    localparam logic [17:0] E_DECODE  = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b01, 3'b000};
    localparam logic [17:0] E_MEMADR  = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000};
    localparam logic [17:0] E_MEMREAD = {7'b1101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] E_MEMWB   = {7'b0000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b100};
    localparam logic [17:0] E_MEMWR_W = {7'b1011000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] E_MEMWR_R = {7'b1011000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [17:0] E_MEMWR_T = {7'b1011000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001};
    localparam logic [17:0] E_EXECR   = {7'b0000000, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000};
    localparam logic [17:0] E_ALUWB   = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [17:0] E_BR_T    = {7'b0000010, 2'b10, 2'b00, 2'b00, 2'b11, 3'b100};
    localparam logic [17:0] E_BR_N    = {7'b0000000, 2'b10, 2'b00, 2'b00, 2'b11, 3'b100};
    localparam logic [17:0] E_BR_ILL  = {7'b0000000, 2'b10, 2'b00, 2'b00, 2'b11, 3'b010};
    localparam logic [17:0] E_JAL     = {7'b0000010, 2'b01, 2'b10, 2'b00, 2'b01, 3'b000};
    localparam logic [17:0] E_ILL     = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       a_req, a_rd, a_wr, a_adr, a_ir, a_pc, a_rw, a_ret, a_ill, a_flt;
    logic [1:0] a_sa, a_sb, a_res, a_op;
    logic [3:0] a_state;
    logic       b_req, b_rd, b_wr, b_adr, b_ir, b_pc, b_rw, b_ret, b_ill, b_flt;
    logic [1:0] b_sa, b_sb, b_res, b_op;
    logic [3:0] b_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_multicycle_controller #(.ENABLE_JAL(1'b0), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(a_req), .mem_read(a_rd), .mem_write(a_wr),
        .adr_src(a_adr), .ir_write(a_ir), .pc_write(a_pc), .reg_write(a_rw),
        .alu_src_a(a_sa), .alu_src_b(a_sb), .result_src(a_res), .alu_op(a_op),
        .instr_retired(a_ret), .illegal_op(a_ill), .mem_fault(a_flt), .state_o(a_state)
    );

    rv_multicycle_controller dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(b_req), .mem_read(b_rd), .mem_write(b_wr),
        .adr_src(b_adr), .ir_write(b_ir), .pc_write(b_pc), .reg_write(b_rw),
        .alu_src_a(b_sa), .alu_src_b(b_sb), .result_src(b_res), .alu_op(b_op),
        .instr_retired(b_ret), .illegal_op(b_ill), .mem_fault(b_flt), .state_o(b_state)
    );

    wire [17:0] a_outs = {a_req, a_rd, a_wr, a_adr, a_ir, a_pc, a_rw, a_sa, a_sb, a_res, a_op, a_ret, a_ill, a_flt};
    wire [17:0] b_outs = {b_req, b_rd, b_wr, b_adr, b_ir, b_pc, b_rw, b_sa, b_sb, b_res, b_op, b_ret, b_ill, b_flt};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_a(input string tag, input logic [3:0] st, input logic [17:0] outs);
        chk({tag, ".state"}, 32'(a_state), 32'(st));
        chk({tag, ".outs"}, 32'(a_outs), 32'(outs));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        exp_a("reset", 4'd0, E_ZERO);

        // lw, memory always ready
        opcode = 7'b0000011; mem_ready = 1'b1; rst_n = 1'b1;
        step(); exp_a("lw.fetch", 4'd1, E_FETCH_R);
        step(); exp_a("lw.decode", 4'd2, E_DECODE);
        step(); exp_a("lw.memadr", 4'd3, E_MEMADR);
        step(); exp_a("lw.memread", 4'd4, E_MEMREAD);
        step(); exp_a("lw.memwb", 4'd5, E_MEMWB);

        // R-type with three wait cycles in FETCH
        opcode = 7'b0110011; mem_ready = 1'b0;
        step(); exp_a("r.fetch1", 4'd1, E_FETCH_W);
        step(); exp_a("r.fetch2", 4'd1, E_FETCH_W);
        step(); exp_a("r.fetch3", 4'd1, E_FETCH_W);
        step(); mem_ready = 1'b1; #1; exp_a("r.fetch4", 4'd1, E_FETCH_R);
        step(); exp_a("r.decode", 4'd2, E_DECODE);
        step(); exp_a("r.execr", 4'd7, E_EXECR);
        step(); exp_a("r.aluwb", 4'd9, E_ALUWB);

        // beq taken, beq not taken, bne taken, unsupported funct3
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        step(); exp_a("beq1.fetch", 4'd1, E_FETCH_R);
        step(); step(); exp_a("beq1.branch", 4'd10, E_BR_T);
        zero = 1'b0;
        step(); step(); step(); exp_a("beq0.branch", 4'd10, E_BR_N);
        funct3 = 3'b001;
        step(); step(); step(); exp_a("bne0.branch", 4'd10, E_BR_T);
        funct3 = 3'b010;
        step(); step(); step(); exp_a("b010.branch", 4'd10, E_BR_ILL);

        // undefined opcode
        opcode = 7'b1111111; funct3 = 3'b000;
        step(); exp_a("ill.fetch", 4'd1, E_FETCH_R);
        step(); exp_a("ill.decode", 4'd2, E_DECODE);
        step(); exp_a("ill.illegal", 4'd12, E_ILL);
        step(); exp_a("ill.after", 4'd1, E_FETCH_R);

        // jal: illegal when disabled, 4-cycle jump when enabled
        opcode = 7'b1101111;
        step(); exp_a("jal_off.decode", 4'd2, E_DECODE);
        step(); exp_a("jal_off.illegal", 4'd12, E_ILL);
        chk("jal_on.state", 32'(b_state), 32'd11);
        chk("jal_on.outs", 32'(b_outs), 32'(E_JAL));
        step(); exp_a("jal_off.after", 4'd1, E_FETCH_R);
        chk("jal_on.aluwb.state", 32'(b_state), 32'd9);
        chk("jal_on.aluwb.outs", 32'(b_outs), 32'(E_ALUWB));

        rst_n = 1'b0; step(); exp_a("resync.reset", 4'd0, E_ZERO);
        rst_n = 1'b1; step(); exp_a("resync.fetch", 4'd1, E_FETCH_R);

        // sw with memory never ready: timeout on the 4th wait cycle
        opcode = 7'b0100011;
        step(); step(); exp_a("swt.memadr", 4'd3, E_MEMADR);
        mem_ready = 1'b0;
        step(); exp_a("swt.w1", 4'd6, E_MEMWR_W);
        step(); exp_a("swt.w2", 4'd6, E_MEMWR_W);
        step(); exp_a("swt.w3", 4'd6, E_MEMWR_W);
        step(); exp_a("swt.w4", 4'd6, E_MEMWR_T);
        chk("swt.notmo.fault", 32'(b_flt), 32'd0);
        step(); exp_a("swt.after", 4'd1, E_FETCH_W);
        chk("swt.notmo.state", 32'(b_state), 32'd6);

        rst_n = 1'b0; mem_ready = 1'b1; step();
        rst_n = 1'b1; step(); exp_a("sw.fetch", 4'd1, E_FETCH_R);

        // sw with ready arriving on the 4th wait cycle: completes normally
        step(); step(); mem_ready = 1'b0;
        step(); exp_a("swr.w1", 4'd6, E_MEMWR_W);
        step(); step();
        step(); mem_ready = 1'b1; #1; exp_a("swr.w4", 4'd6, E_MEMWR_R);
        step(); exp_a("swr.after", 4'd1, E_FETCH_R);

        // reset in the middle of a load's read access
        opcode = 7'b0000011;
        step(); step(); mem_ready = 1'b0;
        step(); exp_a("rst.memread", 4'd4, E_MEMREAD);
        rst_n = 1'b0;
        step(); exp_a("rst.reset", 4'd0, E_ZERO);
        rst_n = 1'b1; mem_ready = 1'b1;
        step(); exp_a("rst.fetch", 4'd1, E_FETCH_R);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
